mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 96 +++++++++
 tb/tb_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ACC, RESP} arb_state_t;
  typedef enum logic       {CORE, DMA}       arb_owner_t;

  localparam int WAIT_MAX = 15;

  function automatic arb_owner_t other_owner(arb_owner_t o);
    return (o == CORE) ? DMA : CORE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of mem_arbiter; master is the arbiter view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          core_req, core_we, core_ack, core_stall;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          dma_req, dma_we, dma_ack, dma_stall;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  modport master (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_ack, core_rdata, core_stall,
    output dma_ack, dma_rdata, dma_stall,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_ack, core_rdata, core_stall,
    input  dma_ack, dma_rdata, dma_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Core/DMA arbiter for the shared instruction/data memory: round-robin grant,
// fixed wait states, registered response and a stall for the core FSM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_bad_wait_states
    $error("mem_arbiter: WAIT_STATES=%0d outside 0..%0d", WAIT_STATES, WAIT_MAX);
  end

  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

  arb_state_t    state;
  arb_owner_t    owner, last_owner;
  logic [3:0]    wait_cnt;
  logic [DW-1:0] rdata_q;
  logic          core_ack_q, dma_ack_q;

  logic in_acc, last_acc, owner_we, other_req;

  assign in_acc    = (state == ACC);
  assign last_acc  = in_acc && (wait_cnt == LAST_CNT);
  assign owner_we  = (owner == DMA) ? bus.dma_we : bus.core_we;
  assign other_req = (owner == CORE) ? bus.dma_req : bus.core_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= CORE;
      last_owner <= DMA;
      wait_cnt   <= '0;
      rdata_q    <= '0;
      core_ack_q <= 1'b0;
      dma_ack_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.core_req || bus.dma_req) begin
            if (bus.core_req && bus.dma_req) owner <= other_owner(last_owner);
            else                             owner <= bus.core_req ? CORE : DMA;
            wait_cnt <= '0;
            state    <= ACC;
          end
        end
        ACC: begin
          if (wait_cnt == LAST_CNT) begin
            rdata_q    <= bus.mem_rdata;
            last_owner <= owner;
            core_ack_q <= (owner == CORE);
            dma_ack_q  <= (owner == DMA);
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          // Owner's req is still high from the finished access; only the
          // other side may be granted here, which gives strict alternation.
          core_ack_q <= 1'b0;
          dma_ack_q  <= 1'b0;
          if (other_req) begin
            owner    <= other_owner(owner);
            wait_cnt <= '0;
            state    <= ACC;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe gated by reset so an aborted access never commits.
  assign bus.mem_en    = in_acc;
  assign bus.mem_we    = last_acc & owner_we & ~reset;
  assign bus.mem_addr  = (in_acc && owner == DMA) ? bus.dma_addr  : bus.core_addr;
  assign bus.mem_wdata = (in_acc && owner == DMA) ? bus.dma_wdata : bus.core_wdata;

  assign bus.core_ack   = core_ack_q;
  assign bus.dma_ack    = dma_ack_q;
  assign bus.core_rdata = rdata_q;
  assign bus.dma_rdata  = rdata_q;
  assign bus.core_stall = bus.core_req & ~core_ack_q;
  assign bus.dma_stall  = bus.dma_req & ~dma_ack_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized two-port run
// checked against a latency/fairness/memory-content model.
module tb_mem_arbiter;

  localparam int WS = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus0 ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();

  mem_arbiter #(.AW(32), .DW(32), .WAIT_STATES(WS)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
  mem_arbiter #(.AW(32), .DW(32), .WAIT_STATES(0))  dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  // 16-word memory behind dut0, plus a back-door load port
  logic [31:0] mem [16];
  logic [31:0] model_mem [16];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  assign bus0.mem_rdata = mem[bus0.mem_addr[5:2]];
  assign bus1.mem_rdata = {16'hC0DE, bus1.mem_addr[15:0]};

  always @(posedge clk) begin
    if (bus0.mem_we)  mem[bus0.mem_addr[5:2]] <= bus0.mem_wdata;
    else if (ld_en)   mem[ld_idx] <= ld_data;
  end

  // A request must stay up until its ack
  logic [1:0] pend = 2'b00;
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(pend[0] && !bus0.core_req)) else begin
        $display("FAIL core_req_dropped: req went low before ack at t=%0t", $time); errs++;
      end
      assert (!(pend[1] && !bus0.dma_req)) else begin
        $display("FAIL dma_req_dropped: req went low before ack at t=%0t", $time); errs++;
      end
    end
    pend <= reset ? 2'b00 : {bus0.dma_req & ~bus0.dma_ack, bus0.core_req & ~bus0.core_ack};
  end

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle_inputs();
    bus0.core_req = 0; bus0.core_we = 0; bus0.core_addr = '0; bus0.core_wdata = '0;
    bus0.dma_req  = 0; bus0.dma_we  = 0; bus0.dma_addr  = '0; bus0.dma_wdata  = '0;
    bus1.core_req = 0; bus1.core_we = 0; bus1.core_addr = '0; bus1.core_wdata = '0;
    bus1.dma_req  = 0; bus1.dma_we  = 0; bus1.dma_addr  = '0; bus1.dma_wdata  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1; ld_idx = 4'(i); ld_data = 32'h5A00_0000 + i * 32'h0001_0111;
      model_mem[i] = ld_data;
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vecs++;
    if ({bus0.busy, bus0.core_ack, bus0.dma_ack, bus0.mem_en, bus0.mem_we, bus0.core_stall, bus0.dma_stall} !== 7'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {bus0.busy, bus0.core_ack, bus0.dma_ack, bus0.mem_en, bus0.mem_we, bus0.core_stall, bus0.dma_stall});
    end
    vecs++;
    if (bus0.core_rdata !== 32'h0 || bus0.dma_rdata !== 32'h0) begin
      errs++; $display("FAIL reset_rdata: got %h/%h expected 0", bus0.core_rdata, bus0.dma_rdata);
    end
  endtask

  task automatic test_core_read();
    logic [3:0] exp_v;
    tick();
    ld_en = 1'b1; ld_idx = 4'd4; ld_data = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;
    tick();
    ld_en = 1'b0;
    bus0.core_req = 1; bus0.core_we = 0; bus0.core_addr = 32'h10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_v = {(c == 1 || c == 2), (c == 3), (c <= 2), 1'b0};
      vecs++;
      if ({bus0.mem_en, bus0.core_ack, bus0.core_stall, bus0.dma_ack} !== exp_v) begin
        errs++; $display("FAIL core_read_ctrl c%0d: en/ack/stall/dack got %b expected %b", c,
          {bus0.mem_en, bus0.core_ack, bus0.core_stall, bus0.dma_ack}, exp_v);
      end
      if (exp_v[3]) begin
        vecs++;
        if (bus0.mem_addr !== 32'h10 || bus0.mem_we !== 1'b0) begin
          errs++; $display("FAIL core_read_addr c%0d: got %h we=%b expected 00000010 we=0", c, bus0.mem_addr, bus0.mem_we);
        end
      end
      if (exp_v[2]) begin
        vecs++;
        if (bus0.core_rdata !== 32'hDEADBEEF) begin
          errs++; $display("FAIL core_read_data: got %h expected deadbeef", bus0.core_rdata);
        end
      end
      tick();
      if (c == 3) bus0.core_req = 0;
    end
  endtask

  task automatic test_dma_write();
    logic [5:0] exp_v;
    bus0.dma_req = 1; bus0.dma_we = 1; bus0.dma_addr = 32'h20; bus0.dma_wdata = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_v = {(c == 1 || c == 2), (c == 2), (c == 3), 1'b0, 1'b0, (c <= 2)};
      vecs++;
      if ({bus0.mem_en, bus0.mem_we, bus0.dma_ack, bus0.core_ack, bus0.core_stall, bus0.dma_stall} !== exp_v) begin
        errs++; $display("FAIL dma_write_ctrl c%0d: got %b expected %b", c,
          {bus0.mem_en, bus0.mem_we, bus0.dma_ack, bus0.core_ack, bus0.core_stall, bus0.dma_stall}, exp_v);
      end
      if (exp_v[5]) begin
        vecs++;
        if (bus0.mem_addr !== 32'h20 || bus0.mem_wdata !== 32'h12345678) begin
          errs++; $display("FAIL dma_write_bus c%0d: got %h/%h expected 00000020/12345678", c, bus0.mem_addr, bus0.mem_wdata);
        end
      end
      tick();
      if (c == 3) begin bus0.dma_req = 0; bus0.dma_we = 0; end
    end
    vecs++;
    if (mem[8] !== 32'h12345678) begin
      errs++; $display("FAIL dma_write_mem: got %h expected 12345678", mem[8]);
    end
    model_mem[8] = 32'h12345678;
  endtask

  task automatic test_tie();
    logic [2:0] exp_v;
    do_reset();
    bus0.core_req = 1; bus0.core_we = 0; bus0.core_addr = 32'h10;
    bus0.dma_req  = 1; bus0.dma_we  = 0; bus0.dma_addr  = 32'h20;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_v = {(c == 1 || c == 2 || c == 4 || c == 5), (c == 3), (c == 6)};
      vecs++;
      if ({bus0.mem_en, bus0.core_ack, bus0.dma_ack} !== exp_v) begin
        errs++; $display("FAIL tie_ctrl c%0d: en/cack/dack got %b expected %b", c,
          {bus0.mem_en, bus0.core_ack, bus0.dma_ack}, exp_v);
      end
      if (exp_v[2]) begin
        vecs++;
        if (bus0.mem_addr !== ((c < 3) ? 32'h10 : 32'h20)) begin
          errs++; $display("FAIL tie_addr c%0d: got %h expected %h", c, bus0.mem_addr, (c < 3) ? 32'h10 : 32'h20);
        end
      end
      if (c == 6) begin
        vecs++;
        if (bus0.dma_rdata !== 32'h12345678) begin
          errs++; $display("FAIL tie_dma_data: got %h expected 12345678", bus0.dma_rdata);
        end
      end
      tick();
      if (c == 3) bus0.core_req = 0;
      if (c == 6) bus0.dma_req = 0;
    end
  endtask

  task automatic test_contention();
    int n = 0;
    int cnt[2] = '{0, 0};
    int who;
    do_reset();
    bus0.core_req = 1; bus0.core_we = 0; bus0.core_addr = 32'h10;
    bus0.dma_req  = 1; bus0.dma_we  = 0; bus0.dma_addr  = 32'h20;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      if (bus0.core_ack || bus0.dma_ack) begin
        who = bus0.dma_ack ? 1 : 0;
        vecs++;
        if (who != n % 2 || c != 3 + 3 * n || (bus0.core_ack && bus0.dma_ack)) begin
          errs++; $display("FAIL contention_order #%0d: got port %0d at cycle %0d expected port %0d at cycle %0d",
            n, who, c, n % 2, 3 + 3 * n);
        end
        vecs++;
        if (bus0.core_rdata !== (who ? 32'h12345678 : 32'hDEADBEEF)) begin
          errs++; $display("FAIL contention_data #%0d: got %h expected %h", n, bus0.core_rdata,
            who ? 32'h12345678 : 32'hDEADBEEF);
        end
        cnt[who]++; n++;
      end
      tick();
      if (cnt[0] == 3) bus0.core_req = 0;
      if (cnt[1] == 3) bus0.dma_req = 0;
    end
    vecs++;
    if (n != 6) begin
      errs++; $display("FAIL contention_count: got %0d acks expected 6", n);
    end
    bus0.core_req = 0; bus0.dma_req = 0;
  endtask

  task automatic test_reset_acc();
    do_reset();
    bus0.dma_req = 1; bus0.dma_we = 1; bus0.dma_addr = 32'h24; bus0.dma_wdata = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vecs++;
      if (bus0.mem_we !== 1'b0 || bus0.dma_ack !== 1'b0) begin
        errs++; $display("FAIL reset_acc_we c%0d: we/ack got %b%b expected 00", c, bus0.mem_we, bus0.dma_ack);
      end
      if (c >= 3) begin
        vecs++;
        if (bus0.busy !== 1'b0 || bus0.mem_en !== 1'b0) begin
          errs++; $display("FAIL reset_acc_idle c%0d: busy/en got %b%b expected 00", c, bus0.busy, bus0.mem_en);
        end
      end
      tick();
      if (c == 1) reset = 1'b1;
      if (c == 2) begin reset = 1'b0; bus0.dma_req = 0; bus0.dma_we = 0; end
    end
    vecs++;
    if (mem[9] !== model_mem[9]) begin
      errs++; $display("FAIL reset_acc_mem: got %h expected %h", mem[9], model_mem[9]);
    end
  endtask

  task automatic test_ws0();
    logic [1:0] exp_v;
    do_reset();
    bus1.core_req = 1; bus1.core_we = 0; bus1.core_addr = 32'h0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_v = {(c == 1 || c == 4), (c == 2 || c == 5)};
      vecs++;
      if ({bus1.mem_en, bus1.core_ack} !== exp_v) begin
        errs++; $display("FAIL ws0_ctrl c%0d: en/ack got %b expected %b", c, {bus1.mem_en, bus1.core_ack}, exp_v);
      end
      if (exp_v[1]) begin
        vecs++;
        if (bus1.mem_addr !== ((c == 1) ? 32'h0 : 32'h4)) begin
          errs++; $display("FAIL ws0_addr c%0d: got %h expected %h", c, bus1.mem_addr, (c == 1) ? 32'h0 : 32'h4);
        end
      end
      if (exp_v[0]) begin
        vecs++;
        if (bus1.core_rdata !== ((c == 2) ? 32'hC0DE0000 : 32'hC0DE0004)) begin
          errs++; $display("FAIL ws0_data c%0d: got %h expected %h", c, bus1.core_rdata,
            (c == 2) ? 32'hC0DE0000 : 32'hC0DE0004);
        end
      end
      tick();
      if (c == 2) bus1.core_addr = 32'h4;
      if (c == 5) bus1.core_req = 0;
    end
  endtask

  // Randomized traffic on both ports. Model: uncontended requests finish in
  // WS+2 cycles, contended ones within 2*WS+4; a waiting port is never passed
  // over twice; reads return the last value written in ack order.
  task automatic test_random();
    int          rem[2] = '{20, 20};
    logic        act[2] = '{1'b0, 1'b0};
    logic        solo[2] = '{1'b0, 1'b0};
    int          start[2] = '{0, 0};
    logic        twe[2];
    logic [3:0]  tidx[2];
    logic [31:0] twd[2];
    logic        ack[2];
    int          last_own = -1;
    int          last_ack_c = -100;
    int          lat;
    do_reset();
    for (int k = 0; k < 3000 && (rem[0] + rem[1] > 0 || act[0] || act[1]); k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && rem[p] > 0 && $urandom_range(0, 3) != 0) begin
          act[p] = 1'b1; start[p] = cyc; rem[p]--;
          twe[p] = 1'($urandom_range(0, 1)); tidx[p] = 4'($urandom_range(0, 15)); twd[p] = $urandom;
        end
      end
      for (int p = 0; p < 2; p++) if (act[p] && start[p] == cyc) solo[p] = !act[1 - p];
      bus0.core_req = act[0]; bus0.core_we = twe[0]; bus0.core_addr = {26'd0, tidx[0], 2'b00}; bus0.core_wdata = twd[0];
      bus0.dma_req  = act[1]; bus0.dma_we  = twe[1]; bus0.dma_addr  = {26'd0, tidx[1], 2'b00}; bus0.dma_wdata  = twd[1];
      @(negedge clk);
      ack[0] = bus0.core_ack; ack[1] = bus0.dma_ack;
      vecs++;
      if (ack[0] && ack[1]) begin
        errs++; $display("FAIL rand_both_ack at cycle %0d: got 11 expected at most one", cyc);
      end
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          vecs++;
          if (!act[p]) begin
            errs++; $display("FAIL rand_spurious_ack port %0d cycle %0d: got ack expected none", p, cyc);
          end else begin
            lat = cyc - start[p];
            vecs++;
            if (solo[p] ? (lat != WS + 2) : (lat < WS + 2 || lat > 2 * WS + 4)) begin
              errs++; $display("FAIL rand_latency port %0d: got %0d expected %s", p, lat, solo[p] ? "exactly WS+2" : "WS+2..2*WS+4");
            end
            vecs++;
            if (last_own == p && act[1 - p] && start[1 - p] <= last_ack_c) begin
              errs++; $display("FAIL rand_fairness port %0d: got second grant at %0d expected port %0d (waiting since %0d)",
                p, cyc, 1 - p, start[1 - p]);
            end
            if (twe[p]) model_mem[tidx[p]] = twd[p];
            else begin
              vecs++;
              if (bus0.core_rdata !== model_mem[tidx[p]]) begin
                errs++; $display("FAIL rand_read port %0d idx %0d: got %h expected %h", p, tidx[p], bus0.core_rdata, model_mem[tidx[p]]);
              end
            end
            act[p] = 1'b0; last_own = p; last_ack_c = cyc;
          end
        end else if (act[p] && cyc - start[p] > 2 * WS + 4) begin
          errs++; $display("FAIL rand_timeout port %0d: got no ack after %0d cycles expected <= %0d", p, cyc - start[p], 2 * WS + 4);
          act[p] = 1'b0;
        end
      end
      tick();
    end
    bus0.core_req = 0; bus0.dma_req = 0;
    vecs++;
    if (rem[0] + rem[1] != 0 || act[0] || act[1]) begin
      errs++; $display("FAIL rand_complete: got %0d outstanding expected 0", rem[0] + rem[1] + int'(act[0]) + int'(act[1]));
    end
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (mem[i] !== model_mem[i]) begin
        errs++; $display("FAIL rand_mem idx %0d: got %h expected %h", i, mem[i], model_mem[i]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    tick();
    preload();
    test_core_read();
    test_dma_write();
    test_tie();
    test_contention();
    test_reset_acc();
    test_ws0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
